// File: rtl/alu_nib_pkg.sv
// Shared encodings for the nibble-serial ALU sequencer: request opcodes,
// sequencer FSM states and the 4-bit alu's ALUOP codes.
package alu_nib_pkg;

  typedef enum logic [1:0] {
    OP_PASS  = 2'b00,
    OP_INC   = 2'b01,
    OP_ADD   = 2'b10,
    OP_LOGIC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_NEG  = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;
  localparam logic [1:0] ALU_INC  = 2'b11;

endpackage

// File: rtl/alu.sv
// 4-bit alu: arithmetic when l=0 (PASS/NEG/ADD/INC), bitwise logic when l=1
// (AND, OR, XOR, NOT A selected by aluop); c_out is forced low for logic.
module alu
  import alu_nib_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic [1:0] aluop,
  input  logic       l,
  output logic [3:0] r,
  output logic       c_out
);

  logic [4:0] sum;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statements can infer a latch.
    sum = '0;
    if (l) begin
      unique case (aluop)
        2'b00:   sum = {1'b0, a & b};
        2'b01:   sum = {1'b0, a | b};
        2'b10:   sum = {1'b0, a ^ b};
        default: sum = {1'b0, ~a};
      endcase
    end else begin
      unique case (aluop)
        ALU_PASS: sum = {1'b0, a} + {4'd0, c_in};
        ALU_NEG:  sum = {1'b0, ~a} + 5'd1;
        ALU_ADD:  sum = {1'b0, a} + {1'b0, b} + {4'd0, c_in};
        default:  sum = {1'b0, a} + 5'd1;
      endcase
    end
    r     = sum[3:0];
    c_out = sum[4];
  end

endmodule

// File: rtl/alu_w_top.sv
// Wrapper pairing the nibble sequencer with one 4-bit alu instance.
module alu_w_top
  import alu_nib_pkg::*;
#(
  parameter  int NIBBLES = 2,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [1:0]   fn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         zero,
  output logic         sign
);

  logic [3:0] alu_a, alu_b, alu_r;
  logic [1:0] alu_op;
  logic       alu_cin, alu_l, alu_cout;

  alu_nib_seq #(.NIBBLES(NIBBLES)) u_seq (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .fn(fn),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done), .result(result),
    .c_out(c_out), .zero(zero), .sign(sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_l(alu_l), .alu_r(alu_r), .alu_cout(alu_cout)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .c_in(alu_cin), .aluop(alu_op), .l(alu_l),
    .r(alu_r), .c_out(alu_cout)
  );

endmodule

// File: rtl/alu_nib_seq.sv
// Nibble-serial sequencer: drives a shared 4-bit alu one nibble per cycle,
// LSB first, chaining carry, and reports a W-bit result with flags.
module alu_nib_seq
  import alu_nib_pkg::*;
#(
  parameter  int NIBBLES = 2,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [1:0]   fn,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         c_out,
  output logic         zero,
  output logic         sign,
  output logic [3:0]   alu_a,
  output logic [3:0]   alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  output logic         alu_l,
  input  logic [3:0]   alu_r,
  input  logic         alu_cout
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e         state_q;
  logic [IW-1:0]  idx_q;
  logic [W-1:0]   a_q, b_q, result_q, result_d;
  op_e            op_q;
  logic [1:0]     fn_q;
  logic           carry_q, carry_d;
  logic           busy_q, done_q, c_out_q, zero_q, sign_q;

  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_cin  = 1'b0;
    alu_op   = ALU_PASS;
    alu_l    = 1'b0;
    result_d = result_q;
    result_d[4*idx_q +: 4] = alu_r;
    // Logic passes never produce a carry; keep the chain untouched.
    carry_d  = (op_q == OP_LOGIC) ? carry_q : alu_cout;
    if (state_q == ST_RUN) begin
      alu_a = a_q[4*idx_q +: 4];
      alu_b = b_q[4*idx_q +: 4];
      unique case (op_q)
        OP_PASS: alu_cin = carry_q;
        OP_INC: begin
          if (idx_q == '0) alu_op = ALU_INC;
          else             alu_cin = carry_q;
        end
        OP_ADD: begin
          alu_op  = ALU_ADD;
          alu_cin = carry_q;
        end
        default: begin
          alu_op = fn_q;
          alu_l  = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_PASS;
      fn_q     <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            op_q     <= op_e'(op);
            fn_q     <= fn;
            carry_q  <= cin;
            idx_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          result_q <= result_d;
          carry_q  <= carry_d;
          if (idx_q == IW'(NIBBLES - 1)) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            c_out_q <= (op_q == OP_LOGIC) ? 1'b0 : carry_d;
            zero_q  <= (result_d == '0);
            sign_q  <= (op_q == OP_LOGIC) ? 1'b0 : result_d[W-1];
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;
  assign sign   = sign_q;

endmodule

// File: tb/tb_alu_nib_seq.sv
// Bench for alu_nib_seq (NIBBLES=2) with a 4-bit alu attached: vector table,
// scoreboard queue, plus re-pulse and mid-run reset sequences.
module tb_alu_nib_seq;
  import alu_nib_pkg::*;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [1:0]   op, fn;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, c_out, zero, sign;
  logic [W-1:0] result;
  logic [3:0]   alu_a, alu_b, alu_r;
  logic [1:0]   alu_op;
  logic         alu_cin, alu_l, alu_cout;

  alu_nib_seq #(.NIBBLES(NIB)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .fn(fn),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done), .result(result),
    .c_out(c_out), .zero(zero), .sign(sign),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_l(alu_l), .alu_r(alu_r), .alu_cout(alu_cout)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .c_in(alu_cin), .aluop(alu_op), .l(alu_l),
    .r(alu_r), .c_out(alu_cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [1:0]   fn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         s;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] o, input logic [1:0] f,
                              input logic [W-1:0] va, input logic [W-1:0] vb,
                              input logic ci, input logic [W-1:0] r,
                              input logic c, input logic z, input logic s);
    vec_t v;
    v.op = o; v.fn = f; v.a = va; v.b = vb; v.cin = ci;
    v.res = r; v.c = c; v.z = z; v.s = s;
    return v;
  endfunction

  // Bitwise model of the alu's logic mode, applied nibble by nibble.
  function automatic logic [W-1:0] logic_model(input logic [1:0] f,
                                               input logic [W-1:0] va,
                                               input logic [W-1:0] vb);
    logic [W-1:0] r;
    logic [3:0]   x, y;
    r = '0;
    for (int i = 0; i < NIB; i++) begin
      x = va[4*i +: 4];
      y = vb[4*i +: 4];
      case (f)
        2'b00:   r[4*i +: 4] = x & y;
        2'b01:   r[4*i +: 4] = x | y;
        2'b10:   r[4*i +: 4] = x ^ y;
        default: r[4*i +: 4] = ~x;
      endcase
    end
    return r;
  endfunction

  function automatic logic [1:0] first_aluop(input vec_t v);
    case (v.op)
      OP_INC:   return ALU_INC;
      OP_ADD:   return ALU_ADD;
      OP_LOGIC: return v.fn;
      default:  return ALU_PASS;
    endcase
  endfunction

  task automatic drive_start(input vec_t v);
    @(negedge clk);
    op = v.op; fn = v.fn; a = v.a; b = v.b; cin = v.cin;
    start = 1'b1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   edges;
    bit   got;
    vec_t e;
    drive_start(v);
    exp_q.push_back(v);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_run"}, busy, 1);
    check({tag, "_alu_a0"}, alu_a, v.a[3:0]);
    check({tag, "_alu_op0"}, alu_op, first_aluop(v));
    check({tag, "_alu_l0"}, alu_l, (v.op == OP_LOGIC));
    edges = 0;
    got   = 0;
    while (!got && edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (done) got = 1;
    end
    e = exp_q.pop_front();
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", tag, edges);
      return;
    end
    check({tag, "_latency"}, edges, NIB);
    check({tag, "_result"}, result, e.res);
    check({tag, "_c_out"}, c_out, e.c);
    check({tag, "_zero"}, zero, e.z);
    check({tag, "_sign"}, sign, e.s);
    check({tag, "_busy_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, "_done_width"}, done, 0);
    check({tag, "_idle_alu_a"}, alu_a, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t v;
    int   dones;
    reset_n = 1'b0; start = 1'b0; op = '0; fn = '0; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_flags", {c_out, zero, sign}, 0);
    check("rst_alu_out", {alu_a, alu_b, alu_cin, alu_op, alu_l}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    vecs.push_back(mk(OP_ADD,   2'b00, 8'h3C, 8'h4F, 1'b0, 8'h8B, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(OP_ADD,   2'b00, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(OP_ADD,   2'b00, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_ADD,   2'b00, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(OP_INC,   2'b00, 8'h0F, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_INC,   2'b00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(OP_PASS,  2'b00, 8'h7E, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(OP_PASS,  2'b00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0));
    for (int f = 0; f < 4; f++) begin
      v = mk(OP_LOGIC, 2'(f), 8'hA5, 8'h3C, 1'b1, '0, 1'b0, 1'b0, 1'b0);
      v.res = logic_model(v.fn, v.a, v.b);
      v.z   = (v.res == '0);
      vecs.push_back(v);
    end

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i], $sformatf("vec%0d", i));

    // start re-pulsed through RUN and DONE must be ignored
    v = mk(OP_ADD, 2'b00, 8'h3C, 8'h4F, 1'b0, 8'h8B, 1'b0, 1'b0, 1'b1);
    drive_start(v);
    exp_q.push_back(v);
    @(posedge clk); #1;
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    v = exp_q.pop_front();
    check("repulse_done_count", dones, 1);
    check("repulse_result", result, v.res);
    check("repulse_busy", busy, 0);

    // reset mid-operation, during the second pass
    v = mk(OP_ADD, 2'b00, 8'h3C, 8'h4F, 1'b0, 8'h8B, 1'b0, 1'b0, 1'b1);
    drive_start(v);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midrst_alu_a_idx1", alu_a, 4'h3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", {c_out, zero, sign}, 0);
    check("midrst_alu_out", {alu_a, alu_b, alu_cin, alu_op, alu_l}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(mk(OP_ADD, 2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
